// File: rtl/face_pkg.sv
// Shared types and helpers for the eigenface projection engine.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package face_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        SCALE   = 3'd2,
        DRAIN   = 3'd3,
        DISCARD = 3'd4
    } proj_state_t;

    // Working width of sat_shift; callers sign-extend their accumulator into it.
    localparam int SAT_W = 64;

    // Arithmetic right shift (floor) followed by saturation to a signed data_w range.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac_w,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sh = acc >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sh > hi) begin
            return hi;
        end else if (sh < lo) begin
            return lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/proj_mac_lane.sv
// One eigen row: accumulates diff*coef per pixel, then rescales and saturates to a weight.
// Latency: MAC result lands at the accepting edge; weight registered at the SCALE edge.
// Backpressure: none internally; the top gates mac_en/scale_en with its handshakes.
module proj_mac_lane
    import face_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     acc_clr,
    input  logic                     mac_en,
    input  logic                     scale_en,
    input  logic signed [DATA_W:0]   diff,
    input  logic signed [DATA_W-1:0] coef,
    output logic signed [DATA_W-1:0] w
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W:0]   diff_x;
    logic signed [2*DATA_W:0]   coef_x;
    logic signed [2*DATA_W:0]   prod;
    logic signed [ACC_W-1:0]    prod_x;
    logic signed [SAT_W-1:0]    acc_x;
    logic signed [SAT_W-1:0]    sat_v;

    // Sign-extend both operands to the full product width so the multiply is exact.
    assign diff_x = {{DATA_W{diff[DATA_W]}}, diff};
    assign coef_x = {{(DATA_W+1){coef[DATA_W-1]}}, coef};
    assign prod   = diff_x * coef_x;
    assign prod_x = {{(ACC_W-2*DATA_W-1){prod[2*DATA_W]}}, prod};
    assign acc_x  = {{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc};
    assign sat_v  = sat_shift(acc_x, FRAC_W, DATA_W);

    // Accumulator and weight register; clearing beats everything, scaling empties the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            w   <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (scale_en) begin
            w   <= sat_v[DATA_W-1:0];
            acc <= '0;
        end else if (mac_en) begin
            acc <= acc + prod_x;
        end
    end

endmodule

// File: rtl/eigen_proj_stream.sv
// Streaming eigenface projection: w[e] = sum_k (f[k]-mean[k])*P[e][k], one MAC lane per row.
// Latency: last pixel accepted at edge T -> first weight valid in cycle T+2, then one per handshake.
// Backpressure: s_ready low during SCALE/DRAIN; DRAIN holds m_* stable while m_ready is low.
module eigen_proj_stream
    import face_pkg::*;
#(
    parameter int  NUM_PIXELS = 161,
    parameter int  NUM_EIG    = 8,
    parameter int  DATA_W     = 16,
    parameter int  FRAC_W     = 8,
    parameter int  ACC_W      = 48,
    localparam int EIG_W      = (NUM_EIG > 1) ? $clog2(NUM_EIG) : 1,
    localparam int PIX_W      = $clog2(NUM_PIXELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [EIG_W-1:0]  cfg_eig,
    input  logic [PIX_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [EIG_W-1:0]  m_idx,
    output logic              m_last,
    output logic              busy,
    output logic              err_len
);

    proj_state_t              state_q, state_d;
    logic [PIX_W-1:0]         cnt_q, cnt_d;
    logic [EIG_W-1:0]         idx_q, idx_d;
    logic                     err_q;
    logic                     beat, last_pix, mac_en, scale_en, len_err, acc_clr, cfg_ok;
    logic signed [DATA_W:0]   diff;
    logic [DATA_W-1:0]        mean_mem [NUM_PIXELS];
    logic [DATA_W-1:0]        p_mem    [NUM_EIG][NUM_PIXELS];
    logic signed [DATA_W-1:0] w_all    [NUM_EIG];

    // Ready is forced low while reset is asserted, not just by the reset state.
    assign s_ready  = rst_n & ((state_q == IDLE) | (state_q == ACCUM) | (state_q == DISCARD));
    assign beat     = s_valid & s_ready;
    assign last_pix = (cnt_q == PIX_W'(NUM_PIXELS - 1));
    assign diff     = {s_data[DATA_W-1], s_data} - {mean_mem[cnt_q][DATA_W-1], mean_mem[cnt_q]};
    assign acc_clr  = clear | len_err;
    assign cfg_ok   = cfg_we && (state_q == IDLE) && (int'(cfg_addr) < NUM_PIXELS)
                      && (!cfg_sel || (int'(cfg_eig) < NUM_EIG));

    // Next-state logic; the IDLE beat is pixel 0 of a new frame, and clear overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mac_en   = 1'b0;
        scale_en = 1'b0;
        len_err  = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    mac_en = 1'b1;
                    if (last_pix) begin
                        cnt_d = '0;
                        if (s_last) begin
                            state_d = SCALE;
                        end else begin
                            len_err = 1'b1;
                            state_d = DISCARD;
                        end
                    end else if (s_last) begin
                        len_err = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ACCUM;
                    end
                end
            end
            SCALE: begin
                scale_en = 1'b1;
                idx_d    = '0;
                state_d  = DRAIN;
            end
            DRAIN: begin
                if (m_ready) begin
                    if (idx_q == EIG_W'(NUM_EIG - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (beat && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            idx_d    = '0;
            mac_en   = 1'b0;
            scale_en = 1'b0;
            len_err  = 1'b0;
        end
    end

    // FSM, pixel counter, output index and the one-cycle length-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= len_err;
        end
    end

    // Mean and eigen-matrix storage; writable only while idle so a frame never sees a torn config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PIXELS; k++) begin
                mean_mem[k] <= '0;
                for (int e = 0; e < NUM_EIG; e++) begin
                    p_mem[e][k] <= '0;
                end
            end
        end else if (cfg_ok) begin
            if (!cfg_sel) begin
                mean_mem[cfg_addr] <= cfg_data;
            end else begin
                p_mem[cfg_eig][cfg_addr] <= cfg_data;
            end
        end
    end

    for (genvar e = 0; e < NUM_EIG; e++) begin : g_lane
        proj_mac_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .acc_clr  (acc_clr),
            .mac_en   (mac_en),
            .scale_en (scale_en),
            .diff     (diff),
            .coef     (p_mem[e][cnt_q]),
            .w        (w_all[e])
        );
    end

    assign m_valid = (state_q == DRAIN);
    assign m_idx   = idx_q;
    assign m_last  = m_valid & (idx_q == EIG_W'(NUM_EIG - 1));
    assign m_data  = w_all[idx_q];
    assign busy    = (state_q != IDLE);
    assign err_len = err_q;

endmodule

// File: tb/tb_eigen_proj_stream.sv
module tb_eigen_proj_stream;

    localparam int NP = 161;
    localparam int NE = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        cfg_we;
    logic        cfg_sel;
    logic [2:0]  cfg_eig;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [2:0]  m_idx;
    logic        m_last;
    logic        busy;
    logic        err_len;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eigen_proj_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_eig  (cfg_eig),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_idx    (m_idx),
        .m_last   (m_last),
        .busy     (busy),
        .err_len  (err_len)
    );

    typedef struct {
        int mean_v;
        int p_mul;
        bit p_per_e;
        int pix;
        int exp_mul;
        bit exp_per_e;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int mean_v, input int p_mul, input bit per_e);
        cfg_we  = 1'b1;
        cfg_sel = 1'b0;
        for (int k = 0; k < NP; k++) begin
            cfg_addr = 8'(k);
            cfg_data = 16'(mean_v);
            tick();
        end
        cfg_sel = 1'b1;
        for (int e = 0; e < NE; e++) begin
            for (int k = 0; k < NP; k++) begin
                cfg_eig  = 3'(e);
                cfg_addr = 8'(k);
                cfg_data = 16'(per_e ? p_mul * (e + 1) : p_mul);
                tick();
            end
        end
        cfg_we = 1'b0;
    endtask

    // Sends n_beats pixels, s_last on index last_at; reports the beat index an err_len pulse follows.
    task automatic send_frame(input int n_beats, input int last_at, input int pix, output int err_beat);
        bit took;
        err_beat = -1;
        for (int i = 0; i < n_beats; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(pix);
            s_last  = (i == last_at);
            took    = 1'b0;
            for (int t = 0; t < 50 && !took; t++) begin
                @(negedge clk);
                if (err_len) err_beat = i - 1;
                took = s_ready;
                tick();
            end
            if (!took) begin
                check("s_ready_timeout", 0, 1);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Counts cycles from the last-beat cycle (=1) until m_valid is seen; returns at that negedge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (m_valid) break;
            tick();
            lat++;
        end
    endtask

    task automatic collect(input int exp_mul, input bit per_e, input int stall_at, input bit poke);
        int ex;
        for (int e = 0; e < NE; e++) begin
            ex = per_e ? exp_mul * (e + 1) : exp_mul;
            if (poke) begin
                cfg_we   = 1'b1;
                cfg_sel  = 1'b0;
                cfg_addr = 8'd0;
                cfg_data = 16'd100;
            end
            check("m_valid", int'(m_valid), 1);
            check("m_idx", int'(m_idx), e);
            check("m_data", int'($signed(m_data)), ex);
            check("m_last", int'(m_last), (e == NE - 1) ? 1 : 0);
            if (e == stall_at) begin
                m_ready = 1'b0;
                repeat (5) begin
                    tick();
                    @(negedge clk);
                    check("stall_m_valid", int'(m_valid), 1);
                    check("stall_m_idx", int'(m_idx), e);
                    check("stall_m_data", int'($signed(m_data)), ex);
                    check("stall_s_ready", int'(s_ready), 0);
                end
                m_ready = 1'b1;
            end
            tick();
            if (e < NE - 1) @(negedge clk);
        end
        cfg_we = 1'b0;
        @(negedge clk);
        check("drain_done_m_valid", int'(m_valid), 0);
        check("drain_done_busy", int'(busy), 0);
    endtask

    task automatic good_frame(input int exp_mul, input int stall_at, input bit poke);
        int eb;
        int lat;
        tick();
        send_frame(NP, NP - 1, 2, eb);
        check("good_no_err", eb, -1);
        wait_out(lat);
        check("latency", lat, 2);
        collect(exp_mul, 1'b1, stall_at, poke);
    endtask

    initial begin
        int eb;
        int lat;
        int seen;

        rst_n    = 1'b0;
        clear    = 1'b0;
        cfg_we   = 1'b0;
        cfg_sel  = 1'b0;
        cfg_eig  = '0;
        cfg_addr = '0;
        cfg_data = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b1;

        vecs[0] = '{mean_v: 1, p_mul:  256, p_per_e: 1, pix:    2, exp_mul:    161, exp_per_e: 1};
        vecs[1] = '{mean_v: 0, p_mul:  256, p_per_e: 0, pix:  256, exp_mul:  32767, exp_per_e: 0};
        vecs[2] = '{mean_v: 0, p_mul:  256, p_per_e: 0, pix: -256, exp_mul: -32768, exp_per_e: 0};
        vecs[3] = '{mean_v: 0, p_mul:    1, p_per_e: 0, pix:    1, exp_mul:      0, exp_per_e: 0};
        vecs[4] = '{mean_v: 0, p_mul:    1, p_per_e: 0, pix:   -1, exp_mul:     -1, exp_per_e: 0};
        vecs[5] = '{mean_v: 3, p_mul: -128, p_per_e: 1, pix:    1, exp_mul:    161, exp_per_e: 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err_len", int'(err_len), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", int'(s_ready), 1);
        check("post_rst_busy", int'(busy), 0);

        // Table of full frames: nominal, saturation both ways, floor rounding, negative coefficients
        for (int v = 0; v < 6; v++) begin
            tick();
            load_cfg(vecs[v].mean_v, vecs[v].p_mul, vecs[v].p_per_e);
            send_frame(NP, NP - 1, vecs[v].pix, eb);
            check("vec_no_err", eb, -1);
            wait_out(lat);
            check("vec_latency", lat, 2);
            collect(vecs[v].exp_mul, vecs[v].exp_per_e, -1, 1'b0);
        end

        // Backpressure in DRAIN
        tick();
        load_cfg(1, 256, 1'b1);
        good_frame(161, 3, 1'b0);

        // Short frame: s_last on beat 100
        tick();
        send_frame(101, 100, 2, eb);
        @(negedge clk);
        check("short_err_len", int'(err_len), 1);
        check("short_busy", int'(busy), 0);
        tick();
        @(negedge clk);
        check("short_err_pulse_end", int'(err_len), 0);
        seen = 0;
        repeat (10) begin
            tick();
            @(negedge clk);
            if (m_valid) seen++;
        end
        check("short_no_output", seen, 0);

        // Long frame: 170 beats, error flagged at beat 160, remainder dropped
        tick();
        send_frame(170, 169, 2, eb);
        check("long_err_beat", eb, 160);
        @(negedge clk);
        check("long_busy", int'(busy), 0);
        check("long_m_valid", int'(m_valid), 0);
        good_frame(161, -1, 1'b0);

        // clear on beat 80 (collides with a valid beat), then config poke during DRAIN
        tick();
        send_frame(80, -1, 2, eb);
        s_valid = 1'b1;
        s_data  = 16'd2;
        clear   = 1'b1;
        tick();
        clear   = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("clear_busy", int'(busy), 0);
        check("clear_m_valid", int'(m_valid), 0);
        check("clear_s_ready", int'(s_ready), 1);
        good_frame(161, -1, 1'b1);
        good_frame(161, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
